// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multicycle processor control path:
// opcodes, ALUop codes, mux selects and the main FSM state encoding.
package cpu_pkg;

   localparam int OPCODE_W = 4;
   localparam int STATE_W  = 4;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = 4'd0;
   localparam logic [OPCODE_W-1:0] OP_ADDI  = 4'd1;
   localparam logic [OPCODE_W-1:0] OP_ORI   = 4'd2;
   localparam logic [OPCODE_W-1:0] OP_LW    = 4'd3;
   localparam logic [OPCODE_W-1:0] OP_SW    = 4'd4;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'd5;
   localparam logic [OPCODE_W-1:0] OP_BNE   = 4'd6;
   localparam logic [OPCODE_W-1:0] OP_J     = 4'd7;
   localparam logic [OPCODE_W-1:0] OP_JAL   = 4'd8;
   localparam logic [OPCODE_W-1:0] OP_JR    = 4'd9;

   localparam logic [1:0] ALUOP_ADD  = 2'd0;
   localparam logic [1:0] ALUOP_SUB  = 2'd1;
   localparam logic [1:0] ALUOP_FUNC = 2'd2;
   localparam logic [1:0] ALUOP_OR   = 2'd3;

   localparam logic [1:0] SRCB_B     = 2'd0;
   localparam logic [1:0] SRCB_TWO   = 2'd1;
   localparam logic [1:0] SRCB_IMM   = 2'd2;
   localparam logic [1:0] SRCB_IMMSH = 2'd3;

   localparam logic [1:0] PCSRC_ALU  = 2'd0;
   localparam logic [1:0] PCSRC_OUT  = 2'd1;
   localparam logic [1:0] PCSRC_JMP  = 2'd2;
   localparam logic [1:0] PCSRC_REG  = 2'd3;

   localparam logic [1:0] REGDST_RT  = 2'd0;
   localparam logic [1:0] REGDST_RD  = 2'd1;
   localparam logic [1:0] REGDST_LNK = 2'd2;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_EXEC_I   = 4'd4,
      S_R_WB     = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_MEM_RD   = 4'd7,
      S_MEM_WB   = 4'd8,
      S_MEM_WR   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_HALT     = 4'd12
   } state_t;

endpackage

// File: rtl/main_control_fsm.sv
// Multicycle main control FSM: sequences fetch/decode/execute/mem/writeback
// and drives every datapath enable plus the ALUop for aluControl.
module main_control_fsm
   import cpu_pkg::*;
#(
   parameter int OPCODE_W = 4,
   parameter int STATE_W  = 4
) (
   input  logic                CLK,
   input  logic                Reset_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                PCWrite,
   output logic                PCWriteCondEQ,
   output logic                PCWriteCondNE,
   output logic                IorD,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                IRWrite,
   output logic                MemtoReg,
   output logic [1:0]          RegDst,
   output logic                RegWrite,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [1:0]          ALUop,
   output logic [1:0]          PCSource,
   output logic                illegal
);

   state_t r_state;
   state_t w_next;

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next        = r_state;
      PCWrite       = 1'b0;
      PCWriteCondEQ = 1'b0;
      PCWriteCondNE = 1'b0;
      IorD          = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      MemtoReg      = 1'b0;
      RegDst        = REGDST_RT;
      RegWrite      = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = SRCB_B;
      ALUop         = ALUOP_ADD;
      PCSource      = PCSRC_ALU;
      illegal       = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            w_next = S_FETCH;
         end
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_TWO;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) w_next = S_DECODE;
         end
         S_DECODE: begin
            // Speculative branch target lands in ALUOut
            ALUSrcB = SRCB_IMMSH;
            case (opcode)
               OP_RTYPE:       w_next = S_EXEC_R;
               OP_ADDI, OP_ORI: w_next = S_EXEC_I;
               OP_LW, OP_SW:   w_next = S_MEM_ADDR;
               OP_BEQ, OP_BNE: w_next = S_BRANCH;
               OP_J, OP_JAL,
               OP_JR:          w_next = S_JUMP;
               default:        w_next = S_HALT;
            endcase
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUop   = ALUOP_FUNC;
            w_next  = S_R_WB;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            ALUop   = (opcode == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
            w_next  = S_R_WB;
         end
         S_R_WB: begin
            RegWrite = 1'b1;
            RegDst   = (opcode == OP_RTYPE) ? REGDST_RD : REGDST_RT;
            w_next   = S_FETCH;
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            w_next  = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) w_next = S_MEM_WB;
         end
         S_MEM_WB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            w_next   = S_FETCH;
         end
         S_MEM_WR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) w_next = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA       = 1'b1;
            ALUop         = ALUOP_SUB;
            PCSource      = PCSRC_OUT;
            PCWriteCondEQ = (opcode == OP_BEQ);
            PCWriteCondNE = (opcode == OP_BNE);
            w_next        = S_FETCH;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = (opcode == OP_JR) ? PCSRC_REG : PCSRC_JMP;
            // Link value is the PC+2 already captured during FETCH
            if (opcode == OP_JAL) begin
               RegWrite = 1'b1;
               RegDst   = REGDST_LNK;
            end
            w_next = S_FETCH;
         end
         S_HALT: begin
            illegal = 1'b1;
            w_next  = S_HALT;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed scoreboard bench for main_control_fsm: expected output vectors
// are queued per cycle and compared against the DUT mid-cycle.
module tb_main_control_fsm;

   logic       CLK;
   logic       Reset_n;
   logic [3:0] opcode;
   logic       mem_ready;
   logic       PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD;
   logic       MemRead, MemWrite, IRWrite, MemtoReg;
   logic [1:0] RegDst;
   logic       RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, ALUop, PCSource;
   logic       illegal;

   int n_cmp = 0;
   int n_err = 0;

   logic [18:0] exp_q[$];
   string       tag_q[$];

   main_control_fsm u_dut (
      .CLK           (CLK),
      .Reset_n       (Reset_n),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .PCWrite       (PCWrite),
      .PCWriteCondEQ (PCWriteCondEQ),
      .PCWriteCondNE (PCWriteCondNE),
      .IorD          (IorD),
      .MemRead       (MemRead),
      .MemWrite      (MemWrite),
      .IRWrite       (IRWrite),
      .MemtoReg      (MemtoReg),
      .RegDst        (RegDst),
      .RegWrite      (RegWrite),
      .ALUSrcA       (ALUSrcA),
      .ALUSrcB       (ALUSrcB),
      .ALUop         (ALUop),
      .PCSource      (PCSource),
      .illegal       (illegal)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [18:0] ev(
      input logic pcw, eq, ne, iord, mr, mw, irw, m2r,
      input logic [1:0] rd,
      input logic rw, sa,
      input logic [1:0] sb, aop, pcs,
      input logic ill
   );
      return {pcw, eq, ne, iord, mr, mw, irw, m2r,
              rd, rw, sa, sb, aop, pcs, ill};
   endfunction

   function automatic logic [18:0] obs();
      return {PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD,
              MemRead, MemWrite, IRWrite, MemtoReg,
              RegDst, RegWrite, ALUSrcA, ALUSrcB,
              ALUop, PCSource, illegal};
   endfunction

   logic [18:0] E0, E_FET, E_FSTL, E_DEC, E_EXR, E_ADDI, E_ORI;
   logic [18:0] E_WBR, E_WBI, E_MRD, E_MWB, E_MWR;
   logic [18:0] E_BEQ, E_BNE, E_J, E_JAL, E_JR, E_HALT;

   task automatic check_now(input string tag, input logic [18:0] e);
      logic [18:0] x;
      string       t;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      x = exp_q.pop_front();
      t = tag_q.pop_front();
      n_cmp++;
      assert (obs() === x) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", t, obs(), x);
      end
   endtask

   task automatic cyc(input string tag, input logic [18:0] e);
      @(negedge CLK);
      check_now(tag, e);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      E0     = '0;
      E_FET  = ev(1,0,0,0,1,0,1,0,0,0,0,1,0,0,0);
      E_FSTL = ev(0,0,0,0,1,0,0,0,0,0,0,1,0,0,0);
      E_DEC  = ev(0,0,0,0,0,0,0,0,0,0,0,3,0,0,0);
      E_EXR  = ev(0,0,0,0,0,0,0,0,0,0,1,0,2,0,0);
      E_ADDI = ev(0,0,0,0,0,0,0,0,0,0,1,2,0,0,0);
      E_ORI  = ev(0,0,0,0,0,0,0,0,0,0,1,2,3,0,0);
      E_WBR  = ev(0,0,0,0,0,0,0,0,1,1,0,0,0,0,0);
      E_WBI  = ev(0,0,0,0,0,0,0,0,0,1,0,0,0,0,0);
      E_MRD  = ev(0,0,0,1,1,0,0,0,0,0,0,0,0,0,0);
      E_MWB  = ev(0,0,0,0,0,0,0,1,0,1,0,0,0,0,0);
      E_MWR  = ev(0,0,0,1,0,1,0,0,0,0,0,0,0,0,0);
      E_BEQ  = ev(0,1,0,0,0,0,0,0,0,0,1,0,1,1,0);
      E_BNE  = ev(0,0,1,0,0,0,0,0,0,0,1,0,1,1,0);
      E_J    = ev(1,0,0,0,0,0,0,0,0,0,0,0,0,2,0);
      E_JAL  = ev(1,0,0,0,0,0,0,0,2,1,0,0,0,2,0);
      E_JR   = ev(1,0,0,0,0,0,0,0,0,0,0,0,0,3,0);
      E_HALT = ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0,1);

      Reset_n   = 1'b0;
      mem_ready = 1'b1;
      opcode    = 4'd0;
      repeat (3) cyc("reset", E0);
      Reset_n = 1'b1;
      cyc("idle", E0);

      // R-type
      cyc("r_fetch", E_FET);
      cyc("r_decode", E_DEC);
      cyc("r_exec", E_EXR);
      cyc("r_wb", E_WBR);

      // addi, with one fetch stall first
      opcode    = 4'd1;
      mem_ready = 1'b0;
      cyc("addi_fstall", E_FSTL);
      mem_ready = 1'b1;
      cyc("addi_fetch", E_FET);
      cyc("addi_decode", E_DEC);
      cyc("addi_exec", E_ADDI);
      cyc("addi_wb", E_WBI);

      opcode = 4'd2;
      cyc("ori_fetch", E_FET);
      cyc("ori_decode", E_DEC);
      cyc("ori_exec", E_ORI);
      cyc("ori_wb", E_WBI);

      // lw with two wait cycles in MEM_RD
      opcode = 4'd3;
      cyc("lw_fetch", E_FET);
      cyc("lw_decode", E_DEC);
      cyc("lw_addr", E_ADDI);
      mem_ready = 1'b0;
      cyc("lw_rd_w0", E_MRD);
      cyc("lw_rd_w1", E_MRD);
      mem_ready = 1'b1;
      cyc("lw_rd_go", E_MRD);
      cyc("lw_wb", E_MWB);

      opcode = 4'd4;
      cyc("sw_fetch", E_FET);
      cyc("sw_decode", E_DEC);
      cyc("sw_addr", E_ADDI);
      cyc("sw_wr", E_MWR);

      opcode = 4'd6;
      cyc("bne_fetch", E_FET);
      cyc("bne_decode", E_DEC);
      cyc("bne_branch", E_BNE);

      opcode = 4'd5;
      cyc("beq_fetch", E_FET);
      cyc("beq_decode", E_DEC);
      cyc("beq_branch", E_BEQ);

      opcode = 4'd7;
      cyc("j_fetch", E_FET);
      cyc("j_decode", E_DEC);
      cyc("j_jump", E_J);

      opcode = 4'd8;
      cyc("jal_fetch", E_FET);
      cyc("jal_decode", E_DEC);
      cyc("jal_jump", E_JAL);

      opcode = 4'd9;
      cyc("jr_fetch", E_FET);
      cyc("jr_decode", E_DEC);
      cyc("jr_jump", E_JR);

      // illegal opcode: absorbing HALT regardless of mem_ready
      opcode = 4'd12;
      cyc("ill_fetch", E_FET);
      cyc("ill_decode", E_DEC);
      for (int i = 0; i < 20; i++) begin
         mem_ready = i[0];
         cyc("halt_hold", E_HALT);
      end
      mem_ready = 1'b1;
      Reset_n   = 1'b0;
      cyc("halt_reset", E0);
      Reset_n = 1'b1;
      opcode  = 4'd0;
      cyc("halt_idle", E0);
      cyc("halt_refetch", E_FET);
      cyc("rt2_decode", E_DEC);
      cyc("rt2_exec", E_EXR);
      cyc("rt2_wb", E_WBR);

      // async reset in the middle of a stalled MEM_WR
      opcode = 4'd4;
      cyc("sw2_fetch", E_FET);
      cyc("sw2_decode", E_DEC);
      cyc("sw2_addr", E_ADDI);
      mem_ready = 1'b0;
      @(negedge CLK);
      check_now("sw2_wr", E_MWR);
      #2;
      Reset_n = 1'b0;
      #1;
      check_now("async_rst", E0);
      n_cmp++;
      assert (MemWrite === 1'b0) else begin
         n_err++;
         $error("FAIL async_memwrite: observed %b expected 0", MemWrite);
      end
      @(posedge CLK);
      #1;
      mem_ready = 1'b1;
      cyc("async_hold", E0);
      Reset_n = 1'b1;
      cyc("async_idle", E0);
      cyc("async_fetch", E_FET);

      n_cmp++;
      assert (exp_q.size() == 0) else begin
         n_err++;
         $error("FAIL queue_drain: observed %0d expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
